branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- IF-stage dynamic branch predictor and redirect controller for the 5-stage pipeline.
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters; gives the predicted next PC from if_pc in the same cycle.
- Carries each prediction into ID alongside IF/ID, compares it with the ID-stage branch resolution, and on mispredict drives PC redirect and IF/ID flush.
- Updates the BTB on the clock edge after resolution; keeps a saturating mispredict counter.

Parameters:
- ENTRIES, 16, number of BTB entries (power of 2).
- IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
- CTR_INIT, 2'b01, counter value on reset and on allocation (01 = weakly not-taken).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_pc  in  32  PC currently being fetched.
- ifid_write  in  1  IF/ID advances this cycle; 0 = hazard stall.
- id_is_branch  in  1  instruction in ID is JUMP/BEQ/BNE/BLT/BGE.
- id_taken  in  1  resolved outcome in ID (JUMP always 1).
- id_target  in  32  resolved taken target.
- id_pcplus4  in  32  PC+4 of the ID instruction.
- pred_taken  out  1  combinational BTB hit with counter[1]=1.
- pred_addr  out  32  id_target-style predicted next PC: BTB target if pred_taken, else if_pc+4.
- redirect  out  1  mispredict: PC mux must take redirect_addr (priority over pred_addr).
- redirect_addr  out  32  corrected next PC.
- ifid_flush  out  1  equals redirect.
- mispredict_count  out  16  saturating count of redirects.

Behaviour:
- Reset (async, rst_n=0):
  - all entries valid=0, counter=CTR_INIT; ID-stage prediction register cleared; mispredict_count=0.
  - Outputs: redirect=0, ifid_flush=0, redirect_addr=0, pred_taken=0, pred_addr=if_pc+4.
  - Reset mid-operation discards everything, including a pending update.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
- ID prediction register {p_taken, p_target}, updated each clock edge:
  - redirect=1 → clear (bubble);
  - else ifid_write=1 → load {pred_taken, BTB target};
  - else hold.
- Resolution (combinational, qualified by ifid_write=1; ifid_write=0 → redirect=0 and no update):
  - branch, taken, !p_taken → redirect to id_target.
  - branch, taken, p_taken, p_target≠id_target → redirect to id_target.
  - branch, !taken, p_taken → redirect to id_pcplus4.
  - !branch, p_taken (stale/aliased) → redirect to id_pcplus4.
  - otherwise redirect=0, redirect_addr=id_pcplus4.
- Update (clock edge, when ifid_write=1), using id_pc = id_pcplus4-4:
  - branch taken, hit: ctr=min(ctr+1,3); target=id_target.
  - branch taken, miss: allocate with valid=1, tag, target, ctr=CTR_INIT+1 (10). Replacement is unconditional.
  - branch not-taken, hit: ctr=max(ctr-1,0).
  - branch not-taken, miss: no change.
  - non-branch with p_taken: invalidate that entry.
- Same-index lookup and update in one cycle: lookup sees the pre-edge value.
- mispredict_count increments on each cycle with redirect=1 and holds at 16'hFFFF.

Decomposition:
- Shared package holds the opcode constants JUMP=6'b000010, BEQ=6'b000100, BNE=6'b000001, BLT=6'b000011, BGE=6'b000101. The decoder producing id_is_branch uses them.
- Package also holds the counter encodings SNT=00, WNT=01, WT=10, ST=11.
- One natural sub-module: sat_counter2, the 2-bit saturating inc/dec next-state function, instantiated once on the update path.

Test Plan:
1. Reset with if_pc=0x40 → pred_taken=0, pred_addr=0x44, redirect=0, mispredict_count=0.
2. ID branch at 0x40 (id_pcplus4=0x44), taken, id_target=0x80, ifid_write=1:
   - that cycle: redirect=1, redirect_addr=0x80, ifid_flush=1;
   - next cycle: count=1, and if_pc=0x40 → pred_taken=1, pred_addr=0x80.
3. Same branch taken twice more, then not-taken:
   - taken resolutions: no redirect, ctr 10→11→11;
   - not-taken: redirect to 0x44, ctr→10, still predicted taken afterwards.
4. Alias: after scenario 2, if_pc=0x80 (same index, different tag) → pred_taken=0, pred_addr=0x84.
5. Stall: mispredicting branch in ID with ifid_write=0 for 2 cycles → redirect=0, count unchanged, BTB unchanged; on release (ifid_write=1) → redirect=1 that cycle.
6. Stale hit: after scenario 2, a non-branch at 0x40 reaches ID with p_taken=1:
   - that cycle: redirect=1, redirect_addr=0x44;
   - next cycle: if_pc=0x40 → pred_taken=0.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared constants for the IF-stage branch predictor: branch opcodes and
// 2-bit counter encodings.
package branch_target_predictor_pkg;

  // Opcodes that resolve as branches in ID
  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_BLT  = 6'b000011;
  localparam logic [5:0] OP_BGE  = 6'b000101;

  // Saturating direction counter encodings
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Used by the ID decoder to produce id_is_branch
  function automatic logic is_branch_op(input logic [5:0] op);
    return op inside {OP_JUMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: fetch PC, ID resolution
// inputs, prediction and redirect outputs.
interface branch_target_predictor_if;
  logic [31:0] if_pc;
  logic        ifid_write;
  logic        id_is_branch;
  logic        id_taken;
  logic [31:0] id_target;
  logic [31:0] id_pcplus4;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        ifid_flush;
  logic [15:0] mispredict_count;

  // Pipeline side
  modport master (
    output if_pc, ifid_write, id_is_branch, id_taken, id_target, id_pcplus4,
    input  pred_taken, pred_addr, redirect, redirect_addr, ifid_flush, mispredict_count
  );

  // Predictor side
  modport slave (
    input  if_pc, ifid_write, id_is_branch, id_taken, id_target, id_pcplus4,
    output pred_taken, pred_addr, redirect, redirect_addr, ifid_flush, mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] next
);

  // Step toward taken on inc, toward not-taken otherwise, clamping at the ends
  always_comb begin
    next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage direct-mapped BTB with 2-bit counters, ID-stage prediction check
// and PC redirect / IF-ID flush generation.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = CTR_WNT
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_target_predictor_if.slave bus
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic        p_taken_q;
  logic [31:0] p_target_q;
  logic [15:0] count_q;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, l_pred;
  logic [31:0]      id_pc;
  logic [1:0]       ctr_upd;
  logic             mispredict;
  logic [31:0]      fix_addr;
  logic             unused_pc_bits;

  assign l_idx = bus.if_pc[IDX_W+1:2];
  assign l_tag = bus.if_pc[31:IDX_W+2];
  assign id_pc = bus.id_pcplus4 - 32'd4;
  assign u_idx = id_pc[IDX_W+1:2];
  assign u_tag = id_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{bus.if_pc[1:0], id_pc[1:0]};

  assign l_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign l_pred = l_hit && ctr_q[l_idx][1];

  assign bus.pred_taken = l_pred;
  assign bus.pred_addr  = l_pred ? target_q[l_idx] : bus.if_pc + 32'd4;

  sat_counter2 u_sat_counter2 (
    .ctr  (ctr_q[u_idx]),
    .inc  (bus.id_taken),
    .next (ctr_upd)
  );

  // Compare the carried prediction with the ID resolution; stalls never redirect
  always_comb begin
    mispredict = 1'b0;
    fix_addr   = bus.id_pcplus4;
    if (bus.ifid_write) begin
      if (bus.id_is_branch) begin
        if (bus.id_taken) begin
          if (!p_taken_q || (p_target_q != bus.id_target)) begin
            mispredict = 1'b1;
            fix_addr   = bus.id_target;
          end
        end else if (p_taken_q) begin
          mispredict = 1'b1;
        end
      end else if (p_taken_q) begin
        // Stale or aliased hit on a non-branch
        mispredict = 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held, whatever ID presents
  assign bus.redirect         = rst_n && mispredict;
  assign bus.ifid_flush       = bus.redirect;
  assign bus.redirect_addr    = rst_n ? fix_addr : 32'd0;
  assign bus.mispredict_count = count_q;

  // BTB state: train on resolved branches, allocate on taken miss, drop stale hits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (bus.ifid_write) begin
      if (bus.id_is_branch) begin
        if (bus.id_taken) begin
          target_q[u_idx] <= bus.id_target;
          if (u_hit) begin
            ctr_q[u_idx] <= ctr_upd;
          end else begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            ctr_q[u_idx]   <= CTR_INIT + 2'd1;
          end
        end else if (u_hit) begin
          ctr_q[u_idx] <= ctr_upd;
        end
      end else if (p_taken_q) begin
        valid_q[u_idx] <= 1'b0;
      end
    end
  end

  // Prediction travelling with IF/ID: bubble on redirect, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
    end else if (bus.redirect) begin
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
    end else if (bus.ifid_write) begin
      p_taken_q  <= l_pred;
      p_target_q <= target_q[l_idx];
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (bus.redirect && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: allocation, training, aliasing,
// stalls, stale hits, target mismatch and mid-run reset.
module tb_branch_target_predictor;
  import branch_target_predictor_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_target_predictor_if bus ();

  branch_target_predictor #(
    .ENTRIES  (16),
    .IDX_W    (4),
    .CTR_INIT (2'b01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic wr, input logic br,
                       input logic tk, input logic [31:0] tgt, input logic [31:0] p4);
    bus.if_pc        = pc;
    bus.ifid_write   = wr;
    bus.id_is_branch = br;
    bus.id_taken     = tk;
    bus.id_target    = tgt;
    bus.id_pcplus4   = p4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b0) begin errors++;
      $display("FAIL reset_pred_taken got %0b exp 0", bus.pred_taken); end
    checks++; if (bus.pred_addr !== 32'h44) begin errors++;
      $display("FAIL reset_pred_addr got %h exp 00000044", bus.pred_addr); end
    checks++; if (bus.redirect !== 1'b0 || bus.ifid_flush !== 1'b0) begin errors++;
      $display("FAIL reset_redirect got %0b/%0b exp 0/0", bus.redirect, bus.ifid_flush); end
    checks++; if (bus.redirect_addr !== 32'h0) begin errors++;
      $display("FAIL reset_redirect_addr got %h exp 00000000", bus.redirect_addr); end
    checks++; if (bus.mispredict_count !== 16'd0) begin errors++;
      $display("FAIL reset_count got %0d exp 0", bus.mispredict_count); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_allocate();
    // Taken branch at 0x40 with no prediction carried
    drive(32'h14, 1'b1, is_branch_op(OP_BEQ), 1'b1, 32'h80, 32'h44);
    @(negedge clk);
    checks++; if (bus.redirect !== 1'b1 || bus.ifid_flush !== 1'b1) begin errors++;
      $display("FAIL alloc_redirect got %0b/%0b exp 1/1", bus.redirect, bus.ifid_flush); end
    checks++; if (bus.redirect_addr !== 32'h80) begin errors++;
      $display("FAIL alloc_redirect_addr got %h exp 00000080", bus.redirect_addr); end
    step();
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.mispredict_count !== 16'd1) begin errors++;
      $display("FAIL alloc_count got %0d exp 1", bus.mispredict_count); end
    checks++; if (bus.pred_taken !== 1'b1 || bus.pred_addr !== 32'h80) begin errors++;
      $display("FAIL alloc_lookup got %0b/%h exp 1/00000080", bus.pred_taken, bus.pred_addr); end
  endtask

  task automatic test_alias();
    bus.if_pc = 32'h80;
    #1;
    checks++; if (bus.pred_taken !== 1'b0 || bus.pred_addr !== 32'h84) begin errors++;
      $display("FAIL alias_lookup got %0b/%h exp 0/00000084", bus.pred_taken, bus.pred_addr); end
  endtask

  task automatic test_train();
    step();
    // Fetch 0x40 so the taken prediction is carried into ID
    drive(32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(32'h40, 1'b1, 1'b1, 1'b1, 32'h80, 32'h44);
      @(negedge clk);
      checks++; if (bus.redirect !== 1'b0) begin errors++;
        $display("FAIL train_taken%0d_redirect got %0b exp 0", i, bus.redirect); end
      step();
    end
    // Counter is saturated at 11; a single not-taken only drops it to 10
    drive(32'h40, 1'b1, 1'b1, 1'b0, 32'h80, 32'h44);
    @(negedge clk);
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== 32'h44) begin errors++;
      $display("FAIL train_nt_redirect got %0b/%h exp 1/00000044", bus.redirect,
               bus.redirect_addr); end
    step();
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b1 || bus.pred_addr !== 32'h80) begin errors++;
      $display("FAIL train_after_nt got %0b/%h exp 1/00000080", bus.pred_taken, bus.pred_addr); end
    checks++; if (bus.mispredict_count !== 16'd2) begin errors++;
      $display("FAIL train_count got %0d exp 2", bus.mispredict_count); end
  endtask

  task automatic test_stall();
    step();
    for (int i = 0; i < 2; i++) begin
      drive(32'h60, 1'b0, 1'b1, 1'b1, 32'hC0, 32'h64);
      @(negedge clk);
      checks++; if (bus.redirect !== 1'b0 || bus.pred_taken !== 1'b0) begin errors++;
        $display("FAIL stall%0d got redirect %0b pred %0b exp 0/0", i, bus.redirect,
                 bus.pred_taken); end
      checks++; if (bus.mispredict_count !== 16'd2) begin errors++;
        $display("FAIL stall%0d_count got %0d exp 2", i, bus.mispredict_count); end
      step();
    end
    bus.ifid_write = 1'b1;
    @(negedge clk);
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== 32'hC0) begin errors++;
      $display("FAIL stall_release got %0b/%h exp 1/000000c0", bus.redirect, bus.redirect_addr); end
    step();
    drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b1 || bus.pred_addr !== 32'hC0) begin errors++;
      $display("FAIL stall_alloc got %0b/%h exp 1/000000c0", bus.pred_taken, bus.pred_addr); end
    checks++; if (bus.mispredict_count !== 16'd3) begin errors++;
      $display("FAIL stall_count got %0d exp 3", bus.mispredict_count); end
  endtask

  task automatic test_stale_hit();
    step();
    drive(32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10);
    step();
    // A non-branch at 0x40 arrives carrying a taken prediction
    drive(32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 32'h44);
    @(negedge clk);
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== 32'h44) begin errors++;
      $display("FAIL stale_redirect got %0b/%h exp 1/00000044", bus.redirect, bus.redirect_addr); end
    step();
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b0 || bus.pred_addr !== 32'h44) begin errors++;
      $display("FAIL stale_invalidate got %0b/%h exp 0/00000044", bus.pred_taken,
               bus.pred_addr); end
    checks++; if (bus.mispredict_count !== 16'd4) begin errors++;
      $display("FAIL stale_count got %0d exp 4", bus.mispredict_count); end
  endtask

  task automatic test_target_mismatch();
    step();
    drive(32'h60, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10);
    step();
    drive(32'h14, 1'b1, 1'b1, 1'b1, 32'hE0, 32'h64);
    @(negedge clk);
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_addr !== 32'hE0) begin errors++;
      $display("FAIL tgt_redirect got %0b/%h exp 1/000000e0", bus.redirect, bus.redirect_addr); end
    step();
    drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b1 || bus.pred_addr !== 32'hE0) begin errors++;
      $display("FAIL tgt_update got %0b/%h exp 1/000000e0", bus.pred_taken, bus.pred_addr); end
    checks++; if (bus.mispredict_count !== 16'd5) begin errors++;
      $display("FAIL tgt_count got %0d exp 5", bus.mispredict_count); end
  endtask

  task automatic test_reset_mid();
    step();
    // Pending update in ID when reset lands mid-cycle
    drive(32'h60, 1'b1, 1'b1, 1'b0, 32'h0, 32'h64);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.redirect !== 1'b0 || bus.redirect_addr !== 32'h0) begin errors++;
      $display("FAIL rstmid_redirect got %0b/%h exp 0/00000000", bus.redirect,
               bus.redirect_addr); end
    checks++; if (bus.mispredict_count !== 16'd0 || bus.pred_taken !== 1'b0) begin errors++;
      $display("FAIL rstmid_state got %0d/%0b exp 0/0", bus.mispredict_count, bus.pred_taken); end
    step();
    rst_n = 1'b1;
    drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.pred_taken !== 1'b0 || bus.pred_addr !== 32'h64) begin errors++;
      $display("FAIL rstmid_btb got %0b/%h exp 0/00000064", bus.pred_taken, bus.pred_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_allocate();
    test_alias();
    test_train();
    test_stall();
    test_stale_hit();
    test_target_mismatch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
